dot_frame_buffer: RTL and testbench
===================================

# dot_frame_buffer

Double-buffered store of dot coordinates between the processor and the VGA controller. The processor fills a back bank of up to DOT_COUNT (x, y) positions, then commits. At the next frame boundary (rising edge of the controller's screenEnd) the banks swap, and the front bank is shown. The display side presents the current pixel coordinate and receives a registered hit flag, which replaces the controller's single hard-wired dot comparison.

## Interface
Parameters:
- DOT_COUNT, 16: number of dot slots per bank.
- IDX_WIDTH, 4: width of the slot index; must satisfy 2^IDX_WIDTH >= DOT_COUNT.
- X_WIDTH, 10: x coordinate width, matching the controller's x.
- Y_WIDTH, 9: y coordinate width, matching the controller's y.

Ports:
- clk  in  1  100 MHz system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write one slot of the back bank.
- wr_idx  in  IDX_WIDTH  slot to write.
- wr_x  in  X_WIDTH  x coordinate for the slot.
- wr_y  in  Y_WIDTH  y coordinate for the slot.
- wr_commit  in  1  back bank complete; request a swap at the next frame end.
- wr_ready  out  1  high in FILL; writes and commits are accepted only while high.
- screenEnd  in  1  controller frame-end flag; a level in the clk25 domain, sampled on clk.
- query_x  in  X_WIDTH  current pixel x from the timing generator.
- query_y  in  Y_WIDTH  current pixel y from the timing generator.
- is_dot  out  1  a valid front-bank slot equals (query_x, query_y).
- frame_tick  out  1  one-cycle pulse on each screenEnd rising edge.
- swap_done  out  1  one-cycle pulse on the cycle the banks swap.

## Operation
Storage:
- Two banks. Each slot holds x, y and a valid bit.
- bank_sel is 1 bit and names the front bank.

Edge detection:
- screenEnd is registered once.
- A rising edge is screenEnd high while the registered copy is low.

FSM states are FILL and PENDING.
- FILL:
  - wr_en with wr_idx < DOT_COUNT writes x and y into the back-bank slot and sets its valid bit.
  - wr_en with wr_idx >= DOT_COUNT is ignored.
  - wr_commit moves the FSM to PENDING.
  - If wr_en and wr_commit occur in the same cycle, the write lands first and is included in the commit.
- PENDING:
  - wr_en and wr_commit are ignored and wr_ready is 0.
  - On a screenEnd rising edge: bank_sel toggles, the new back bank (the old front) has all valid bits cleared, swap_done pulses, and the FSM returns to FILL.
- If a commit and a screenEnd rising edge arrive in the same cycle while in FILL, the FSM enters PENDING and the swap waits for the next rising edge. A swap never happens on the commit cycle.

Lookup and pulses:
- is_dot is the OR, over all front-bank slots, of (valid && x == query_x && y == query_y).
- Several matching slots still give is_dot = 1.
- frame_tick fires on every rising edge, in either state.

Reset:
- bank_sel = 0, all valid bits in both banks = 0, state = FILL.
- is_dot = 0, frame_tick = 0, swap_done = 0, wr_ready = 1 in the cycle after reset is released.
- Reset during PENDING discards the pending bank; no swap_done pulse is produced.

## Timing
- is_dot is registered: a query presented in cycle n is answered in cycle n+1. The controller delays its color path by one clk to match.
- Write to back bank: the slot is updated at the clock edge.
- Commit: wr_ready falls in the cycle after wr_commit is sampled.
- Swap:
  - The screenEnd rise is sampled at edge k.
  - bank_sel toggles and swap_done is high during cycle k+1.
  - is_dot reflects the new front bank for queries presented from cycle k+1 onward.
- frame_tick: high during the same cycle as swap_done, and also on edges where no swap occurs.
- screenEnd stays high for 4 clk (one clk25 period), which yields exactly one frame_tick per frame.

## Test plan
- Reset, then query (0,0) -> is_dot=0, wr_ready=1, bank_sel=0; frame_tick pulses once per screenEnd rise.
- In FILL, write slot 3 = (310,50) and commit; pulse screenEnd -> swap_done for 1 cycle; query (310,50) gives is_dot=1 one cycle later; query (311,50) gives 0.
- Commit in the same cycle as a screenEnd rise -> no swap; the next screenEnd rise swaps; wr_ready stays 0 in between.
- In PENDING, wr_en to slot 0 = (5,5) -> ignored; after the swap, query (5,5) gives is_dot=0.
- Write wr_idx=15 = (639,479), then wr_idx=16 (DOT_COUNT=16) = (1,1), commit and swap -> (639,479) hits; (1,1) does not.
- Commit, then assert reset before screenEnd -> no swap_done; state FILL; is_dot=0 for all previously written coordinates.

Source files
------------

// File: rtl/dot_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : dot_frame_buffer
// Purpose  : Double-buffered dot coordinate store with frame-synchronous swap
//            and a registered per-pixel hit lookup for the VGA controller.
// Revision : 1.0 - initial release
// ============================================================================
module dot_frame_buffer #(
    parameter int DOT_COUNT = 16,
    parameter int IDX_WIDTH = 4,
    parameter int X_WIDTH   = 10,
    parameter int Y_WIDTH   = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_idx,
    input  logic [X_WIDTH-1:0]   wr_x,
    input  logic [Y_WIDTH-1:0]   wr_y,
    input  logic                 wr_commit,
    output logic                 wr_ready,
    input  logic                 screenEnd,
    input  logic [X_WIDTH-1:0]   query_x,
    input  logic [Y_WIDTH-1:0]   query_y,
    output logic                 is_dot,
    output logic                 frame_tick,
    output logic                 swap_done
);

    // Storage spans the full index range; slots at or above DOT_COUNT are never written.
    localparam int SLOTS = 1 << IDX_WIDTH;

    localparam logic [0:0] ST_FILL    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;

    logic [0:0]         r_state;
    logic               r_bank_sel;
    logic               r_screen_end_d;
    logic               r_is_dot;
    logic               r_frame_tick;
    logic               r_swap_done;
    logic [X_WIDTH-1:0] r_x     [2][SLOTS];
    logic [Y_WIDTH-1:0] r_y     [2][SLOTS];
    logic [SLOTS-1:0]   r_valid [2];

    logic                 w_rise;
    logic                 w_back;
    logic                 w_wr_ok;
    logic                 w_swap;
    logic [DOT_COUNT-1:0] w_match;

    assign w_rise  = screenEnd && !r_screen_end_d;
    assign w_back  = ~r_bank_sel;
    assign w_wr_ok = (r_state == ST_FILL) && wr_en && (int'(wr_idx) < DOT_COUNT);
    assign w_swap  = (r_state == ST_PENDING) && w_rise;

    generate
        for (genvar i = 0; i < DOT_COUNT; i++) begin : g_match
            assign w_match[i] = r_valid[r_bank_sel][i]
                             && (r_x[r_bank_sel][i] == query_x)
                             && (r_y[r_bank_sel][i] == query_y);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_FILL;
            r_bank_sel     <= 1'b0;
            r_screen_end_d <= 1'b0;
            r_is_dot       <= 1'b0;
            r_frame_tick   <= 1'b0;
            r_swap_done    <= 1'b0;
            r_valid[0]     <= '0;
            r_valid[1]     <= '0;
        end else begin
            r_screen_end_d <= screenEnd;
            r_frame_tick   <= w_rise;
            r_swap_done    <= w_swap;
            r_is_dot       <= |w_match;

            case (r_state)
                ST_FILL: begin
                    // A commit never swaps in its own cycle, even alongside a rise.
                    if (wr_commit) begin
                        r_state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (w_rise) begin
                        r_state             <= ST_FILL;
                        r_bank_sel          <= ~r_bank_sel;
                        r_valid[r_bank_sel] <= '0;
                    end
                end
                default: r_state <= ST_FILL;
            endcase

            if (w_wr_ok) begin
                r_valid[w_back][wr_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_x[w_back][wr_idx] <= wr_x;
            r_y[w_back][wr_idx] <= wr_y;
        end
    end

    assign wr_ready   = (r_state == ST_FILL);
    assign is_dot     = r_is_dot;
    assign frame_tick = r_frame_tick;
    assign swap_done  = r_swap_done;

endmodule
`default_nettype wire

// File: tb/tb_dot_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dot_frame_buffer
// Purpose  : Self-checking bench for dot_frame_buffer (query table + sequences).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dot_frame_buffer;

    localparam int DOT_COUNT = 16;
    localparam int IDX_WIDTH = 5;
    localparam int X_WIDTH   = 10;
    localparam int Y_WIDTH   = 9;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 wr_en = 1'b0;
    logic [IDX_WIDTH-1:0] wr_idx = '0;
    logic [X_WIDTH-1:0]   wr_x = '0;
    logic [Y_WIDTH-1:0]   wr_y = '0;
    logic                 wr_commit = 1'b0;
    logic                 wr_ready;
    logic                 screenEnd = 1'b0;
    logic [X_WIDTH-1:0]   query_x = '0;
    logic [Y_WIDTH-1:0]   query_y = '0;
    logic                 is_dot;
    logic                 frame_tick;
    logic                 swap_done;

    dot_frame_buffer #(
        .DOT_COUNT(DOT_COUNT),
        .IDX_WIDTH(IDX_WIDTH),
        .X_WIDTH  (X_WIDTH),
        .Y_WIDTH  (Y_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_x      (wr_x),
        .wr_y      (wr_y),
        .wr_commit (wr_commit),
        .wr_ready  (wr_ready),
        .screenEnd (screenEnd),
        .query_x   (query_x),
        .query_y   (query_y),
        .is_dot    (is_dot),
        .frame_tick(frame_tick),
        .swap_done (swap_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 phase;
        logic [X_WIDTH-1:0] x;
        logic [Y_WIDTH-1:0] y;
        logic               exp;
    } vec_t;

    typedef struct {
        int   due;
        logic exp;
        int   qx;
        int   qy;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Each query's expected hit is due one cycle after it is presented.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
            sb_t e;
            e = sb.pop_front();
            checks++;
            if (is_dot !== e.exp || e.due != cyc) begin
                failures++;
                $display("FAIL is_dot(%0d,%0d) cycle %0d: got %b, expected %b at cycle %0d",
                         e.qx, e.qy, cyc, is_dot, e.exp, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic add(input int p, input int x, input int y, input logic e);
        vec_t v;
        v.phase = p;
        v.x     = X_WIDTH'(x);
        v.y     = Y_WIDTH'(y);
        v.exp   = e;
        vecs.push_back(v);
    endtask

    task automatic run_phase(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].phase == p) begin
                sb_t e;
                query_x = vecs[i].x;
                query_y = vecs[i].y;
                e.due = cyc + 1;
                e.exp = vecs[i].exp;
                e.qx  = int'(vecs[i].x);
                e.qy  = int'(vecs[i].y);
                sb.push_back(e);
                tick();
            end
        end
        query_x = '0;
        query_y = '0;
        tick();
    endtask

    task automatic write(input int idx, input int x, input int y, input logic commit);
        wr_en     = 1'b1;
        wr_idx    = IDX_WIDTH'(idx);
        wr_x      = X_WIDTH'(x);
        wr_y      = Y_WIDTH'(y);
        wr_commit = commit;
        tick();
        wr_en     = 1'b0;
        wr_commit = 1'b0;
    endtask

    task automatic commit();
        wr_commit = 1'b1;
        tick();
        wr_commit = 1'b0;
        check("wr_ready_after_commit", wr_ready, 1'b0);
    endtask

    // screenEnd held high for four clocks, as one clk25 period would give.
    task automatic pulse_screen(input logic exp_swap, input logic exp_ready);
        screenEnd = 1'b1;
        tick();
        check("frame_tick_rise", frame_tick, 1'b1);
        check("swap_done_rise", swap_done, exp_swap);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frame_tick_hold", frame_tick, 1'b0);
            check("swap_done_hold", swap_done, 1'b0);
        end
        screenEnd = 1'b0;
        tick();
        check("frame_tick_low", frame_tick, 1'b0);
        check("swap_done_low", swap_done, 1'b0);
        check("wr_ready_after_frame", wr_ready, exp_ready);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        add(0, 0, 0, 0);     add(0, 310, 50, 0);  add(0, 639, 479, 0);
        add(1, 310, 50, 1);  add(1, 311, 50, 0);  add(1, 310, 51, 0);  add(1, 0, 0, 0);
        add(2, 100, 200, 0); add(2, 310, 50, 1);  add(2, 5, 5, 0);
        add(3, 100, 200, 1); add(3, 5, 5, 0);     add(3, 310, 50, 0);
        add(4, 639, 479, 1); add(4, 1, 1, 0);     add(4, 20, 30, 1);
        add(4, 7, 7, 1);     add(4, 100, 200, 0);
        add(5, 50, 60, 0);   add(5, 639, 479, 0); add(5, 20, 30, 0);   add(5, 310, 50, 0);

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("reset_wr_ready", wr_ready, 1'b1);
        check("reset_is_dot", is_dot, 1'b0);
        check("reset_frame_tick", frame_tick, 1'b0);
        check("reset_swap_done", swap_done, 1'b0);
        run_phase(0);
        pulse_screen(1'b0, 1'b1);

        // Basic write, commit and swap.
        write(3, 310, 50, 1'b0);
        commit();
        pulse_screen(1'b1, 1'b1);
        run_phase(1);

        // Commit coinciding with a rise must defer the swap.
        write(7, 100, 200, 1'b0);
        wr_commit = 1'b1;
        screenEnd = 1'b1;
        tick();
        wr_commit = 1'b0;
        check("same_cycle_frame_tick", frame_tick, 1'b1);
        check("same_cycle_swap_done", swap_done, 1'b0);
        check("same_cycle_wr_ready", wr_ready, 1'b0);
        repeat (3) tick();
        screenEnd = 1'b0;
        write(0, 5, 5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pending_wr_ready", wr_ready, 1'b0);
            check("pending_swap_done", swap_done, 1'b0);
        end
        run_phase(2);
        pulse_screen(1'b1, 1'b1);
        run_phase(3);

        // Index boundary, write merged into commit, duplicate coordinates.
        write(15, 639, 479, 1'b0);
        write(16, 1, 1, 1'b0);
        write(4, 7, 7, 1'b0);
        write(5, 7, 7, 1'b0);
        write(2, 20, 30, 1'b1);
        check("write_commit_wr_ready", wr_ready, 1'b0);
        pulse_screen(1'b1, 1'b1);
        run_phase(4);

        // Reset while pending drops the committed bank.
        write(1, 50, 60, 1'b0);
        commit();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("reset_pending_swap_done", swap_done, 1'b0);
        end
        reset = 1'b0;
        tick();
        check("post_reset_wr_ready", wr_ready, 1'b1);
        check("post_reset_is_dot", is_dot, 1'b0);
        pulse_screen(1'b0, 1'b1);
        run_phase(5);

        repeat (4) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
